pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
- Parametrised successor to the single-channel PWM datapath/control pair.
- One shared period counter drives CHANNELS independent duty comparators.
- Edge-aligned and centre-aligned modes.
- Double-buffered (shadow → active) period/duty/mode registers, so software updates take effect only at a period boundary and never produce glitch pulses.

Parameters:
- WIDTH, 16, bit width of period, duty and counter.
- CHANNELS, 4, number of PWM outputs sharing the counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = counter runs; 0 = counter idle, outputs low.
- period_in  input  WIDTH  requested period, in counts.
- duty_in  input  CHANNELS*WIDTH  requested duty per channel; channel i at bits [i*WIDTH +: WIDTH].
- mode_in  input  1  0 = edge-aligned, 1 = centre-aligned.
- load  input  1  single-cycle strobe; captures period_in/duty_in/mode_in into shadow.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_end  output  1  one-cycle pulse on the first cycle of each new period.
- load_pending  output  1  shadow holds values not yet applied.
- load_ack  output  1  one-cycle pulse when shadow is transferred to active.

Behaviour:
- Reset (reset=0, async):
  - cnt=0, dir=up.
  - All shadow and active registers = 0.
  - pwm_out=0, period_end=0, load_pending=0, load_ack=0.
  - Reset mid-period aborts immediately; after release the counter restarts from 0.
- Edge mode (per = active period):
  - cnt counts 0,1,…,per-1, then wraps to 0.
  - Boundary cycle: cnt==per-1.
- Centre mode:
  - cnt counts up 0…per-1, then down per-1…0, so every value appears twice and the period is 2*per cycles.
  - Boundary cycle: dir=down and cnt==0.
  - Turnaround: the cycle after cnt==per-1 while up, dir flips to down and cnt holds per-1.
- per==0: cnt held 0; every cycle is a boundary; pwm_out=0.
- per==1, edge mode: cnt stays 0; every cycle is a boundary.
- Compare rule:
  - pwm_out[i] registers (enable && cnt < duty_act[i]), with one-cycle latency from cnt.
  - Edge mode: high for min(duty, per) cycles per period.
  - Centre mode: high for 2*min(duty, per) cycles, centred on the boundary.
  - duty==0 gives constant 0; duty>=per gives constant 1 (when per>0).
- Comparisons are unsigned WIDTH-bit; no arithmetic overflow is possible.
- Shadow:
  - load=1 captures inputs into shadow and sets load_pending.
  - A repeated load before transfer overwrites the shadow (latest wins).
- Transfer:
  - Occurs on any boundary cycle while pending, or on any cycle with enable=0 while pending.
  - Active registers take the shadow values on the next edge; load_pending clears; load_ack pulses for one cycle.
  - If load=1 in the same cycle as a transfer, the transfer uses the load inputs directly (bypass), and pending ends cleared.
- At a transfer the next period starts with cnt=0 and dir=up, so a mode change always starts cleanly.
- enable=0:
  - cnt forced to 0, dir up.
  - pwm_out goes 0 on the next edge.
  - period_end=0.
- enable rising: the first counting cycle has cnt=0; period_end pulses in that cycle.
- period_end:
  - Registered.
  - High in the cycle after each boundary while enable=1.
  - Not asserted while per==0.

Test Plan:
1. Reset, load per=10, duty0=3, duty1=0, duty2=10, duty3=15, edge mode, enable=1 → per 10-cycle period: pwm_out[0] high 3 cycles, [1] always 0, [2] and [3] always 1; period_end every 10 cycles.
2. Centre mode, per=8, duty0=2 → period 16 cycles; pwm_out[0] high 4 contiguous cycles spanning the boundary; period_end every 16 cycles.
3. Running with per=10, duty0=3; load duty0=7 at cnt=4 → current period keeps 3 high cycles; load_pending=1 until boundary; load_ack pulses once; next period has 7 high cycles.
4. Two loads (duty0=5, then duty0=6) within one period → only duty0=6 is applied; a single load_ack; load coincident with the boundary cycle applies immediately via bypass.
5. enable=0 with a pending load → transfer on the next cycle, pwm_out=0, cnt=0; enable=1 → period_end in the first cycle and a clean period from cnt=0.
6. Assert reset (low) at cnt=6 mid-period → all outputs 0 asynchronously; after release with per=0 held, pwm_out stays 0 and period_end never asserts.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if
//   Groups the PWM control inputs and status outputs of pwm_multi_channel.
//   master: drives enable/period_in/duty_in/mode_in/load, observes outputs.
//   slave : the PWM block itself.
//   duty_in packs channel i at bits [i*WIDTH +: WIDTH].
interface pwm_multi_channel_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic [WIDTH-1:0]          period_in;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic                      mode_in;
  logic                      load;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_end;
  logic                      load_pending;
  logic                      load_ack;

  modport master (
    output enable, period_in, duty_in, mode_in, load,
    input  pwm_out, period_end, load_pending, load_ack
  );

  modport slave (
    input  enable, period_in, duty_in, mode_in, load,
    output pwm_out, period_end, load_pending, load_ack
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   One shared period counter feeding CHANNELS duty comparators. Supports
//   edge-aligned (0..per-1) and centre-aligned (up 0..per-1, down per-1..0)
//   counting. period/duty/mode are double-buffered: load captures into a
//   shadow set, which moves to the active set only at a period boundary or
//   while the counter is idle, so outputs never glitch mid-period.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - slave modport: enable, period_in, duty_in, mode_in, load in;
//           pwm_out, period_end, load_pending, load_ack out
module pwm_multi_channel #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pwm_multi_channel_if.slave   bus
);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_q, dir_d;          // 1 = counting down
  logic [WIDTH-1:0]          per_sh_q, per_sh_d;
  logic [CHANNELS*WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic                      mode_sh_q, mode_sh_d;
  logic [WIDTH-1:0]          per_act_q, per_act_d;
  logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_act_d;
  logic                      mode_act_q, mode_act_d;
  logic                      pending_q, pending_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      period_end_q, period_end_d;
  logic                      load_ack_q, load_ack_d;

  logic [WIDTH-1:0]          per_last;
  logic                      per_zero;
  logic                      boundary;
  logic                      period_start;
  logic                      xfer;

  assign per_last = per_act_q - WIDTH'(1);
  assign per_zero = (per_act_q == '0);

  // Last cycle of the current period. per==0 makes every cycle a boundary.
  assign boundary = per_zero ||
                    (mode_act_q ? (dir_q && (cnt_q == '0)) : (cnt_q == per_last));

  // An idle counter behaves like a permanent boundary: the next enabled
  // cycle starts a fresh period from cnt=0, and shadow may move to active.
  assign period_start = !bus.enable || boundary;

  // A load arriving on a start cycle bypasses the shadow and applies at once.
  assign xfer = (pending_q || bus.load) && period_start;

  always_comb begin
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    per_sh_d     = per_sh_q;
    duty_sh_d    = duty_sh_q;
    mode_sh_d    = mode_sh_q;
    per_act_d    = per_act_q;
    duty_act_d   = duty_act_q;
    mode_act_d   = mode_act_q;
    pending_d    = pending_q;
    pwm_d        = '0;
    period_end_d = 1'b0;
    load_ack_d   = xfer;

    if (bus.load) begin
      per_sh_d  = bus.period_in;
      duty_sh_d = bus.duty_in;
      mode_sh_d = bus.mode_in;
      pending_d = 1'b1;
    end

    if (xfer) begin
      per_act_d  = bus.load ? bus.period_in : per_sh_q;
      duty_act_d = bus.load ? bus.duty_in   : duty_sh_q;
      mode_act_d = bus.load ? bus.mode_in   : mode_sh_q;
      pending_d  = 1'b0;
    end

    // Flags the first cycle of the period that begins after this edge; it
    // is gated by enable at the output so an idle counter reports nothing
    // yet the first enabled cycle reports a period start.
    period_end_d = period_start && (per_act_d != '0);

    if (period_start) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!mode_act_q) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (!dir_q) begin
      // Centre turnaround: hold the top value for one more cycle.
      if (cnt_q == per_last) dir_d = 1'b1;
      else                   cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end

    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = bus.enable && !per_zero &&
                 (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      per_sh_q     <= '0;
      duty_sh_q    <= '0;
      mode_sh_q    <= 1'b0;
      per_act_q    <= '0;
      duty_act_q   <= '0;
      mode_act_q   <= 1'b0;
      pending_q    <= 1'b0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      per_sh_q     <= per_sh_d;
      duty_sh_q    <= duty_sh_d;
      mode_sh_q    <= mode_sh_d;
      per_act_q    <= per_act_d;
      duty_act_q   <= duty_act_d;
      mode_act_q   <= mode_act_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_end   = period_end_q && bus.enable;
  assign bus.load_pending = pending_q;
  assign bus.load_ack     = load_ack_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel
//   Scoreboard bench for pwm_multi_channel. A phase-position model predicts
//   the registered outputs for every edge; predictions are queued when the
//   stimulus for that cycle is applied and popped when the cycle is sampled.
//   Directed window counts (high cycles, period_end spacing, load_ack count)
//   cross-check the scenarios with hand-derived constants.
module tb_pwm_multi_channel;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic             en  = 1'b0;
  logic             ld  = 1'b0;
  logic             md  = 1'b0;
  logic [WIDTH-1:0] pin = '0;
  logic [WIDTH-1:0] din [CHANNELS];

  assign bus.enable    = en;
  assign bus.load      = ld;
  assign bus.mode_in   = md;
  assign bus.period_in = pin;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_duty
    assign bus.duty_in[g*WIDTH +: WIDTH] = din[g];
  end

  typedef struct packed {
    logic [CHANNELS-1:0] pwm;
    logic                pe;
    logic                pend;
    logic                ack;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: position within the period rather than a counter/direction.
  int m_per, m_mode, m_pos, m_pend, sh_per, sh_mode;
  int m_duty [CHANNELS];
  int sh_duty[CHANNELS];

  // Sampled outputs and window statistics.
  logic [CHANNELS-1:0] s_pwm;
  logic s_pe, s_pend, s_ack;
  int hi[CHANNELS];
  int pe_cnt, ack_cnt;

  task automatic model_reset();
    m_per = 0; m_mode = 0; m_pos = 0; m_pend = 0; sh_per = 0; sh_mode = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_duty[i] = 0; sh_duty[i] = 0;
    end
  endtask

  task automatic model_step();
    int   len, c;
    logic bnd, xf;
    exp_t e;
    len = (m_per == 0) ? 1 : (m_mode != 0 ? 2 * m_per : m_per);
    if (m_per == 0)       c = 0;
    else if (m_mode == 0) c = m_pos;
    else                  c = (m_pos < m_per) ? m_pos : 2 * m_per - 1 - m_pos;
    bnd = (m_pos == len - 1) || !en;
    xf  = ((m_pend != 0) || ld) && bnd;
    for (int i = 0; i < CHANNELS; i++)
      e.pwm[i] = en && (m_per != 0) && (c < m_duty[i]);
    if (ld) begin
      sh_per = int'(pin); sh_mode = int'(md); m_pend = 1;
      for (int i = 0; i < CHANNELS; i++) sh_duty[i] = int'(din[i]);
    end
    if (xf) begin
      m_per = sh_per; m_mode = sh_mode; m_pend = 0;
      for (int i = 0; i < CHANNELS; i++) m_duty[i] = sh_duty[i];
    end
    e.pe   = bnd && (m_per != 0);
    e.ack  = xf;
    e.pend = (m_pend != 0);
    m_pos  = bnd ? 0 : m_pos + 1;
    sb.push_back(e);
  endtask

  // Called just after a rising edge with this cycle's inputs applied.
  task automatic tick();
    exp_t e;
    #2;
    s_pwm  = bus.pwm_out;
    s_pe   = bus.period_end;
    s_pend = bus.load_pending;
    s_ack  = bus.load_ack;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pwm_out",      32'(s_pwm),  32'(e.pwm));
      check("period_end",   32'(s_pe),   32'(e.pe & en));
      check("load_pending", 32'(s_pend), 32'(e.pend));
      check("load_ack",     32'(s_ack),  32'(e.ack));
    end
    for (int i = 0; i < CHANNELS; i++) hi[i] += int'(s_pwm[i]);
    pe_cnt  += int'(s_pe);
    ack_cnt += int'(s_ack);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < CHANNELS; i++) hi[i] = 0;
    pe_cnt = 0; ack_cnt = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_pe();
    int k;
    k = 0;
    s_pe = 1'b0;
    while (!s_pe && k < 40) begin
      tick();
      k++;
    end
    if (!s_pe) check("wait_pe_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input int p, input logic m, input int d0, input int d1,
                         input int d2, input int d3);
    pin = WIDTH'(p); md = m;
    din[0] = WIDTH'(d0); din[1] = WIDTH'(d1); din[2] = WIDTH'(d2); din[3] = WIDTH'(d3);
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0;
    #1;
    check("rst_pwm",  32'(bus.pwm_out),      32'd0);
    check("rst_pe",   32'(bus.period_end),   32'd0);
    check("rst_pend", 32'(bus.load_pending), 32'd0);
    check("rst_ack",  32'(bus.load_ack),     32'd0);
    model_reset();
    sb.delete();
    z = '0;
    sb.push_back(z);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CHANNELS; i++) din[i] = '0;
    clr_stats();
    @(posedge clk);
    #1;
    do_reset();

    // 1: edge mode, per=10, duties 3/0/10/15
    en = 1'b1;
    do_load(10, 1'b0, 3, 0, 10, 15);
    wait_pe();
    clr_stats();
    run(10);
    check("t1_hi0", 32'(hi[0]), 32'd3);
    check("t1_hi1", 32'(hi[1]), 32'd0);
    check("t1_hi2", 32'(hi[2]), 32'd10);
    check("t1_hi3", 32'(hi[3]), 32'd10);
    check("t1_pe",  32'(pe_cnt), 32'd1);

    // 2: centre mode, per=8, duty0=2
    do_load(8, 1'b1, 2, 0, 0, 0);
    wait_pe();
    clr_stats();
    run(16);
    check("t2_hi0", 32'(hi[0]), 32'd4);
    check("t2_pe",  32'(pe_cnt), 32'd1);

    // 3: reload duty0=7 at cnt=4 of a duty0=3 period
    do_load(10, 1'b0, 3, 0, 10, 0);
    wait_pe();
    clr_stats();
    run(3);
    do_load(10, 1'b0, 7, 0, 10, 0);
    tick();
    check("t3_pending", 32'(s_pend), 32'd1);
    run(4);
    check("t3_hi0_old", 32'(hi[0]), 32'd3);
    check("t3_ack_none", 32'(ack_cnt), 32'd0);
    clr_stats();
    run(10);
    check("t3_ack", 32'(ack_cnt), 32'd1);
    check("t3_hi0_new", 32'(hi[0]), 32'd7);
    check("t3_pe", 32'(pe_cnt), 32'd1);

    // 4: two loads in one period, latest wins; then bypass on the boundary
    wait_pe();
    clr_stats();
    do_load(10, 1'b0, 5, 0, 10, 0);
    do_load(10, 1'b0, 6, 0, 10, 0);
    run(7);
    check("t4_ack_none", 32'(ack_cnt), 32'd0);
    clr_stats();
    run(10);
    check("t4_ack", 32'(ack_cnt), 32'd1);
    check("t4_hi0", 32'(hi[0]), 32'd6);
    wait_pe();
    run(8);
    do_load(10, 1'b0, 2, 0, 10, 0);
    tick();
    check("t4_bypass_ack",  32'(s_ack),  32'd1);
    check("t4_bypass_pend", 32'(s_pend), 32'd0);
    clr_stats();
    run(10);
    check("t4_bypass_hi0", 32'(hi[0]), 32'd2);

    // 5: disable with a pending load, then re-enable
    do_load(10, 1'b0, 4, 0, 10, 0);
    en = 1'b0;
    tick();
    tick();
    check("t5_ack",  32'(s_ack),  32'd1);
    check("t5_pend", 32'(s_pend), 32'd0);
    check("t5_pwm",  32'(s_pwm),  32'd0);
    run(2);
    en = 1'b1;
    tick();
    check("t5_pe_first", 32'(s_pe), 32'd1);
    clr_stats();
    run(10);
    check("t5_hi0", 32'(hi[0]), 32'd4);
    check("t5_pe",  32'(pe_cnt), 32'd1);

    // 6: reset at cnt=6, then per=0 held
    wait_pe();
    run(5);
    #1;
    check("t6_pre_rst_pwm2", 32'(bus.pwm_out[2]), 32'd1);
    pin = '0; md = 1'b0;
    for (int i = 0; i < CHANNELS; i++) din[i] = '0;
    do_reset();
    clr_stats();
    run(30);
    check("t6_pe_never", 32'(pe_cnt), 32'd0);
    check("t6_pwm_never", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
